program_sequencer: RTL and testbench

//  Global controller for the cell_core array: fetches one instruction per step from the

---
 rtl/program_sequencer_pkg.sv | 25 ++
 rtl/program_sequencer_if.sv | 33 +++
 rtl/program_sequencer_divergence_stack_ctrl.sv | 31 +++
 rtl/program_sequencer.sv | 132 +++++++++++++
 tb/tb_program_sequencer.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/program_sequencer_pkg.sv
// ISA types, opcodes and field decoders shared by the program sequencer and the cell array.
package program_sequencer_pkg;

  typedef logic [7:0]  pc_t;
  typedef logic [3:0]  sp_t;
  typedef logic [15:0] instruction_t;
  typedef logic [3:0]  opcode_t;

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, COMMIT} seq_state_t;

  localparam opcode_t OP_NOP  = 4'h0;
  localparam opcode_t OP_HALT = 4'h1;
  localparam opcode_t OP_JMP  = 4'h2;
  localparam opcode_t OP_BR   = 4'h3;
  localparam opcode_t OP_JOIN = 4'h4;

  function automatic opcode_t get_opcode(input instruction_t ins);
    return ins[15:12];
  endfunction

  function automatic logic [11:0] get_immediate(input instruction_t ins);
    return ins[11:0];
  endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// Sequencer bus: host control, instruction memory port and cell broadcast signals.
interface program_sequencer_if
  import program_sequencer_pkg::*;
#(
  parameter int GEN_W = 16
) ();
  logic             start;
  logic             pause;
  pc_t              imem_addr;
  instruction_t     imem_rdata;
  instruction_t     instruction;
  pc_t              next_program_counter;
  sp_t              next_stack_pointer;
  logic             global_enable;
  logic             diverge_any;
  logic             commit;
  logic             done;
  logic             busy;
  logic             error;
  logic [GEN_W-1:0] gen_count;

  modport master (
    input  start, pause, imem_rdata, diverge_any,
    output imem_addr, instruction, next_program_counter, next_stack_pointer,
           global_enable, commit, done, busy, error, gen_count
  );

  modport slave (
    output start, pause, imem_rdata, diverge_any,
    input  imem_addr, instruction, next_program_counter, next_stack_pointer,
           global_enable, commit, done, busy, error, gen_count
  );
endinterface

// File: rtl/program_sequencer_divergence_stack_ctrl.sv
// Divergence stack pointer: push on diverging branch, pop on join, flags illegal moves.
module divergence_stack_ctrl
  import program_sequencer_pkg::*;
#(
  parameter int STACK_DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic push,
  input  logic pop,
  output sp_t  sp,
  output logic overflow,
  output logic underflow
);
  // An illegal move leaves sp untouched; the sequencer aborts the generation on the flag.
  assign overflow  = push && (sp == sp_t'(STACK_DEPTH - 1));
  assign underflow = pop && (sp == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp <= '0;
    end else if (clear) begin
      sp <= '0;
    end else if (push && !overflow) begin
      sp <= sp + sp_t'(1);
    end else if (pop && !underflow) begin
      sp <= sp - sp_t'(1);
    end
  end
endmodule

// File: rtl/program_sequencer.sv
// Global fetch/broadcast controller for the cell array; one generation per start.
// Optional SEQ_WATCHDOG_EN aborts a generation that runs MAX_STEPS instructions without HALT.
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int PROG_BASE   = 0,
  parameter int STACK_DEPTH = 8,
  parameter int GEN_W       = 16,
  parameter int MAX_STEPS   = 1024
) (
  input logic                 clk,
  input logic                 rst,
  program_sequencer_if.master bus
);
  seq_state_t       state;
  pc_t              pc;
  pc_t              next_pc;
  opcode_t          opcode;
  sp_t              sp;
  logic             in_exec;
  logic             start_gen;
  logic             push;
  logic             pop;
  logic             overflow;
  logic             underflow;
  logic             wd_err;
  logic             abort;
  logic             commit_r;
  logic             done_r;
  logic             error_r;
  logic [GEN_W-1:0] gen_cnt;

  if (MAX_STEPS < 1 || STACK_DEPTH < 2 || STACK_DEPTH > 16) begin : g_bad_cfg
    $error("program_sequencer: unsupported MAX_STEPS/STACK_DEPTH");
  end

  assign in_exec   = (state == EXEC);
  assign start_gen = (state == IDLE) && bus.start;
  assign opcode    = get_opcode(bus.imem_rdata);
  assign next_pc   = (opcode == OP_JMP) ? pc_t'(get_immediate(bus.imem_rdata)) : pc + pc_t'(1);
  assign push      = in_exec && (opcode == OP_BR) && bus.diverge_any;
  assign pop       = in_exec && (opcode == OP_JOIN);

  divergence_stack_ctrl #(.STACK_DEPTH(STACK_DEPTH)) u_stack (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_gen),
    .push      (push),
    .pop       (pop),
    .sp        (sp),
    .overflow  (overflow),
    .underflow (underflow)
  );

`ifdef SEQ_WATCHDOG_EN
  localparam int STEP_W = $clog2(MAX_STEPS + 1);
  logic [STEP_W-1:0] steps;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      steps <= '0;
    end else if (start_gen) begin
      steps <= '0;
    end else if (in_exec) begin
      steps <= steps + STEP_W'(1);
    end
  end

  // A HALT landing exactly on the last budgeted step still commits.
  assign wd_err = in_exec && (opcode != OP_HALT) && (steps == STEP_W'(MAX_STEPS - 1));
`else
  assign wd_err = 1'b0;
`endif

  assign abort = overflow || underflow || wd_err;

  assign bus.imem_addr            = pc;
  assign bus.instruction          = in_exec ? bus.imem_rdata : '0;
  assign bus.next_program_counter = in_exec ? next_pc : pc;
  assign bus.next_stack_pointer   = sp;
  assign bus.global_enable        = in_exec && (opcode != OP_HALT);
  assign bus.busy                 = (state != IDLE);
  assign bus.commit               = commit_r;
  assign bus.done                 = done_r;
  assign bus.error                = error_r;
  assign bus.gen_count            = gen_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pc       <= pc_t'(PROG_BASE);
      commit_r <= 1'b0;
      done_r   <= 1'b0;
      error_r  <= 1'b0;
      gen_cnt  <= '0;
    end else begin
      commit_r <= 1'b0;
      done_r   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            pc      <= pc_t'(PROG_BASE);
            error_r <= 1'b0;
            state   <= FETCH;
          end
        end
        FETCH: begin
          if (!bus.pause) state <= EXEC;
        end
        EXEC: begin
          pc <= next_pc;
          if (abort) begin
            error_r <= 1'b1;
            done_r  <= 1'b1;
            state   <= IDLE;
          end else if (opcode == OP_HALT) begin
            commit_r <= 1'b1;
            done_r   <= 1'b1;
            state    <= COMMIT;
          end else begin
            state <= FETCH;
          end
        end
        COMMIT: begin
          gen_cnt <= gen_cnt + GEN_W'(1);
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: a reference program interpreter predicts each EXEC broadcast.
module tb_program_sequencer;
  import program_sequencer_pkg::*;

  localparam int SD = 2;
  localparam int MS = 4;
  localparam int GW = 16;

  typedef struct {
    pc_t          pc;
    instruction_t ins;
    pc_t          npc;
    sp_t          sp;
    logic         ge;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  program_sequencer_if #(.GEN_W(GW)) bus ();

  program_sequencer #(
    .PROG_BASE   (0),
    .STACK_DEPTH (SD),
    .GEN_W       (GW),
    .MAX_STEPS   (MS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  instruction_t mem [256];
  always @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr];

  rec_t expq [$];
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   cyc        = 0;
  int   start_cyc  = 0;
  int   commit_cyc = -1;
  int   commits    = 0;
  int   dones      = 0;
  int   ge_cnt     = 0;
  int   exp_gen    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      if (bus.commit) begin
        commits++;
        commit_cyc = cyc - start_cyc;
      end
      if (bus.done) dones++;
      if (bus.global_enable) ge_cnt++;
      if (bus.global_enable || bus.instruction != '0) begin
        if (expq.size() == 0) begin
          check_eq("exec_unexpected_qsize", 32'(expq.size()), 32'd1);
        end else begin
          rec_t r;
          r = expq.pop_front();
          check_eq("exec_imem_addr", bus.imem_addr, r.pc);
          check_eq("exec_instruction", bus.instruction, r.ins);
          check_eq("exec_next_pc", bus.next_program_counter, r.npc);
          check_eq("exec_next_sp", bus.next_stack_pointer, r.sp);
          check_eq("exec_global_enable", bus.global_enable, r.ge);
        end
      end
    end
  end

  // Reference interpreter: outc 0 = still running at limit, 1 = commit, 2 = abort.
  task automatic model(input int limit, input logic div, output int outc, output sp_t fsp, output int nge);
    pc_t          pc;
    sp_t          sp;
    int           step;
    rec_t         r;
    instruction_t ins;
    logic [3:0]   op;
    pc = '0; sp = '0; step = 0; outc = 0; nge = 0;
    while (step < limit) begin
      ins   = mem[pc];
      op    = ins[15:12];
      r.pc  = pc;
      r.ins = ins;
      r.npc = (op == OP_JMP) ? ins[7:0] : pc + 8'd1;
      r.sp  = sp;
      r.ge  = (op != OP_HALT);
      expq.push_back(r);
      step++;
      if (op != OP_HALT) nge++;
      if (op == OP_HALT) begin
        outc = 1;
        break;
      end
      if (op == OP_BR && div) begin
        if (int'(sp) == SD - 1) begin
          outc = 2;
          break;
        end
        sp = sp + 4'd1;
      end else if (op == OP_JOIN) begin
        if (sp == 0) begin
          outc = 2;
          break;
        end
        sp = sp - 4'd1;
      end
`ifdef SEQ_WATCHDOG_EN
      if (step == MS) begin
        outc = 2;
        break;
      end
`endif
      pc = r.npc;
    end
    fsp = sp;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = '0;
  endtask

  task automatic do_start();
    @(negedge clk);
    bus.start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic run_gen(input string tag, input logic div, input int pause_cycles);
    int  outc;
    int  nge;
    sp_t fsp;
    int  c0;
    int  d0;
    model(200, div, outc, fsp, nge);
    if (outc == 1) exp_gen++;
    c0 = commits;
    d0 = dones;
    ge_cnt = 0;
    bus.diverge_any = div;
    do_start();
    check_eq({tag, "_busy_start"}, bus.busy, 1'b1);
    check_eq({tag, "_error_cleared"}, bus.error, 1'b0);
    // A second start while busy must not restart the program.
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < pause_cycles; i++) begin
      @(negedge clk);
      check_eq({tag, "_pause_ge"}, bus.global_enable, 1'b0);
      check_eq({tag, "_pause_addr"}, bus.imem_addr, 8'd0);
    end
    bus.pause = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (dones != d0) break;
    end
    repeat (2) @(posedge clk);
    #1;
    check_eq({tag, "_done_pulses"}, 32'(dones - d0), 32'd1);
    check_eq({tag, "_commit_pulses"}, 32'(commits - c0), (outc == 1) ? 32'd1 : 32'd0);
    check_eq({tag, "_error"}, bus.error, (outc == 2));
    check_eq({tag, "_gen_count"}, bus.gen_count, 16'(exp_gen));
    check_eq({tag, "_sp"}, bus.next_stack_pointer, fsp);
    check_eq({tag, "_ge_cycles"}, 32'(ge_cnt), 32'(nge));
    check_eq({tag, "_queue_drained"}, 32'(expq.size()), 32'd0);
    check_eq({tag, "_busy_end"}, bus.busy, 1'b0);
    expq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  outc;
    int  nge;
    sp_t fsp;
    int  c0;
    int  d0;
    clear_mem();
    bus.start       = 1'b0;
    bus.pause       = 1'b0;
    bus.diverge_any = 1'b0;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_commit", bus.commit, 1'b0);
    check_eq("rst_done", bus.done, 1'b0);
    check_eq("rst_error", bus.error, 1'b0);
    check_eq("rst_gen_count", bus.gen_count, 16'd0);
    check_eq("rst_global_enable", bus.global_enable, 1'b0);
    check_eq("rst_imem_addr", bus.imem_addr, 8'd0);
    check_eq("rst_instruction", bus.instruction, 16'd0);
    check_eq("rst_next_pc", bus.next_program_counter, 8'd0);
    check_eq("rst_next_sp", bus.next_stack_pointer, 4'd0);
    @(negedge clk);
    rst = 1'b1;

    mem[0] = {OP_NOP, 12'd0};
    mem[1] = {OP_NOP, 12'd0};
    mem[2] = {OP_HALT, 12'd0};
    run_gen("nop_halt", 1'b0, 0);
    check_eq("nop_halt_commit_cycle", 32'(commit_cyc), 32'd7);

    clear_mem();
    mem[0] = {OP_JMP, 12'd5};
    mem[1] = {OP_HALT, 12'd0};
    mem[5] = {OP_HALT, 12'd0};
    run_gen("jmp5", 1'b0, 0);

    clear_mem();
    mem[0] = {OP_BR, 12'd0};
    mem[1] = {OP_BR, 12'd0};
    mem[2] = {OP_HALT, 12'd0};
    run_gen("br_overflow", 1'b1, 0);

    clear_mem();
    mem[0] = {OP_JOIN, 12'd0};
    mem[1] = {OP_HALT, 12'd0};
    run_gen("join_underflow", 1'b0, 0);

    clear_mem();
    mem[0] = {OP_BR, 12'd0};
    mem[1] = {OP_JOIN, 12'd0};
    mem[2] = {OP_NOP, 12'd0};
    mem[3] = {OP_HALT, 12'd0};
    run_gen("br_join", 1'b1, 0);

    clear_mem();
    mem[0] = {OP_NOP, 12'd0};
    mem[1] = {OP_HALT, 12'd0};
    bus.pause = 1'b1;
    run_gen("pause", 1'b0, 10);

    // Asynchronous reset in the middle of a generation.
    clear_mem();
    mem[8] = {OP_HALT, 12'd0};
    model(100, 1'b0, outc, fsp, nge);
    c0 = commits;
    do_start();
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("midrst_busy", bus.busy, 1'b0);
    check_eq("midrst_gen_count", bus.gen_count, 16'd0);
    check_eq("midrst_commit", bus.commit, 1'b0);
    expq.delete();
    exp_gen = 0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("midrst_no_commit", 32'(commits - c0), 32'd0);

    clear_mem();
    mem[0] = {OP_JMP, 12'd0};
`ifdef SEQ_WATCHDOG_EN
    run_gen("watchdog", 1'b0, 0);
`else
    model(6, 1'b0, outc, fsp, nge);
    d0 = dones;
    do_start();
    for (int i = 0; i < 60 && expq.size() != 0; i++) @(negedge clk);
    check_eq("loop_queue_drained", 32'(expq.size()), 32'd0);
    check_eq("loop_still_busy", bus.busy, 1'b1);
    check_eq("loop_no_error", bus.error, 1'b0);
    check_eq("loop_no_done", 32'(dones - d0), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("loop_rst_busy", bus.busy, 1'b0);
    expq.delete();
    @(negedge clk);
    rst = 1'b1;
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
